// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  localparam logic       PORT0      = 1'b0;
  localparam logic       PORT1      = 1'b1;
  localparam logic [1:0] ALIGN_MASK = 2'b11;

endpackage

// File: rtl/dmem_rr_pick.sv
// Combinational 2-way round-robin select: on a tie, the port that did not win last time wins.
module dmem_rr_pick
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_owner,
  output logic       grant_valid,
  output logic       grant_id
);

  always_comb begin
    grant_valid = |req;
    grant_id    = PORT0;
    if (req == 2'b11) begin
      grant_id = ~last_owner;
    end else if (req[1]) begin
      grant_id = PORT1;
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares a single-ported data memory between two request/ack ports with
// fixed two-cycle latency and round-robin tie breaking.
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned width     = 32,
  parameter int unsigned AddrWidth = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 p0_req,
  input  logic                 p0_we,
  input  logic [AddrWidth-1:0] p0_addr,
  input  logic [width-1:0]     p0_wdata,
  output logic                 p0_ack,
  output logic                 p0_err,
  output logic [width-1:0]     p0_rdata,
  input  logic                 p1_req,
  input  logic                 p1_we,
  input  logic [AddrWidth-1:0] p1_addr,
  input  logic [width-1:0]     p1_wdata,
  output logic                 p1_ack,
  output logic                 p1_err,
  output logic [width-1:0]     p1_rdata,
  output logic                 mem_we,
  output logic [AddrWidth-1:0] mem_addr,
  output logic [width-1:0]     mem_wdata,
  input  logic [width-1:0]     mem_rdata,
  output logic                 busy
);

  state_e               state_q;
  logic                 owner_q;
  logic                 last_owner_q;
  logic                 p0_ack_q, p1_ack_q, p0_err_q, p1_err_q;
  logic [width-1:0]     p0_rdata_q, p1_rdata_q;

  logic                 grant_valid;
  logic                 grant_id;
  logic                 sel_we;
  logic [AddrWidth-1:0] sel_addr;
  logic [width-1:0]     sel_wdata;
  logic                 misaligned;

  dmem_rr_pick u_pick (
    .req         ({p1_req, p0_req}),
    .last_owner  (last_owner_q),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  // Owner's request fields, used both for the memory drive and completion.
  always_comb begin
    sel_we     = (owner_q == PORT1) ? p1_we    : p0_we;
    sel_addr   = (owner_q == PORT1) ? p1_addr  : p0_addr;
    sel_wdata  = (owner_q == PORT1) ? p1_wdata : p0_wdata;
    misaligned = |(sel_addr[1:0] & ALIGN_MASK);
  end

  // Memory is only driven during ACCESS; a misaligned write never reaches it.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (state_q == ACCESS) begin
      mem_we    = sel_we & ~misaligned;
      mem_addr  = sel_addr;
      mem_wdata = sel_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= PORT0;
      last_owner_q <= PORT1;
      p0_ack_q     <= 1'b0;
      p1_ack_q     <= 1'b0;
      p0_err_q     <= 1'b0;
      p1_err_q     <= 1'b0;
      p0_rdata_q   <= '0;
      p1_rdata_q   <= '0;
    end else begin
      p0_ack_q <= 1'b0;
      p1_ack_q <= 1'b0;
      p0_err_q <= 1'b0;
      p1_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_valid) begin
            state_q      <= ACCESS;
            owner_q      <= grant_id;
            last_owner_q <= grant_id;
          end
        end
        ACCESS: begin
          state_q <= IDLE;
          // Writes leave the owner's read-data register untouched.
          if (owner_q == PORT0) begin
            p0_ack_q <= 1'b1;
            p0_err_q <= misaligned;
            if (misaligned)   p0_rdata_q <= '0;
            else if (!sel_we) p0_rdata_q <= mem_rdata;
          end else begin
            p1_ack_q <= 1'b1;
            p1_err_q <= misaligned;
            if (misaligned)   p1_rdata_q <= '0;
            else if (!sel_we) p1_rdata_q <= mem_rdata;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign p0_ack   = p0_ack_q;
  assign p1_ack   = p1_ack_q;
  assign p0_err   = p0_err_q;
  assign p1_err   = p1_err_q;
  assign p0_rdata = p0_rdata_q;
  assign p1_rdata = p1_rdata_q;
  assign busy     = (state_q == ACCESS);

endmodule

// File: doc/dmem_port_arbiter.md
# dmem_port_arbiter

Two-port arbiter that shares the single-ported data memory (word-addressed by `Address >> 2`, combinational read, write on falling clock edge) between the CPU load/store path (port 0) and a secondary requester such as a debug or DMA master (port 1). Each access is a request/acknowledge transaction with fixed two-cycle latency. Simultaneous requests are resolved round-robin. The arbiter drives the memory's `MemWrite`, `Address` and `Write_data` inputs and returns registered read data to the winning port.

## Interface
- `width`, 32, data word width
- `AddrWidth`, 32, byte-address width
- `clk`  in  1  system clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `p0_req` / `p1_req`  in  1  request, held until matching ack
- `p0_we` / `p1_we`  in  1  1 = write, 0 = read; stable while req
- `p0_addr` / `p1_addr`  in  AddrWidth  byte address; stable while req
- `p0_wdata` / `p1_wdata`  in  width  write data; stable while req
- `p0_ack` / `p1_ack`  out  1  one-cycle completion pulse
- `p0_err` / `p1_err`  out  1  high with ack when the access was misaligned
- `p0_rdata` / `p1_rdata`  out  width  read data, valid in ack cycle, held until next ack on that port
- `mem_we`  out  1  to memory MemWrite
- `mem_addr`  out  AddrWidth  to memory Address
- `mem_wdata`  out  width  to memory Write_data
- `mem_rdata`  in  width  from memory Read_data
- `busy`  out  1  high while in ACCESS

## Operation
- States:
  - IDLE: no transaction in progress.
  - ACCESS: the owner's request is driven to memory.
- IDLE transitions:
  - No req: stay in IDLE.
  - Any req: latch owner, go to ACCESS.
- ACCESS transitions: always return to IDLE after one cycle.
- Round-robin pick:
  - Only one req high: that port wins.
  - Both high: the port other than `last_owner` wins.
  - `last_owner` updates on every grant.
- Memory drive in ACCESS:
  - `mem_addr` and `mem_wdata` come from the owner's inputs.
  - `mem_we` = owner `we` AND aligned.
- Memory drive in IDLE: `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
- Alignment:
  - `addr[1:0] != 0` is misaligned.
  - Misaligned access: no write, owner rdata captured as 0, err=1 with ack.
- Read: at the rising edge ending ACCESS, `mem_rdata` is registered into the owner's rdata register.
- Write: rdata register keeps its previous value.
- Non-owner outputs are unaffected by the owner's transaction.

## Timing
- Reset values:
  - state=IDLE, `last_owner`=1 (port 0 wins the first tie).
  - All ack/err=0, both rdata=0.
  - `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `busy`=0.
- Cycle N: req sampled high in IDLE.
- Cycle N+1: ACCESS.
  - Memory signals valid; memory write occurs at the falling edge mid-cycle.
  - `busy`=1.
- Cycle N+2: IDLE with owner ack=1 (and err if misaligned); rdata valid.
- A req still high in the ack cycle is a new request.
  - A requester finishing must drop req combinationally on ack.
  - Back-to-back throughput: one access per 2 cycles.
- Loser's req is held and granted at the next IDLE cycle.
  - With both held continuously, grants strictly alternate.
- Reset mid-ACCESS:
  - Next state is IDLE; no ack is issued.
  - A write whose falling edge already passed in that cycle is committed. The requester must reissue.
- Req deasserted during ACCESS is a protocol violation. The transaction completes and acks anyway.

## Structure
- Shared package `dmem_arb_pkg` holds:
  - State encoding: IDLE=0, ACCESS=1.
  - Owner constants: PORT0=0, PORT1=1.
  - `ALIGN_MASK`=2'b11.
- Sub-module `dmem_rr_pick`: combinational 2-way round-robin select.
  - Inputs: `req[1:0]`, `last_owner`.
  - Outputs: `grant_valid`, `grant_id`.
- All registers (state, owner, `last_owner`, acks, errs, rdata) live in the top. Memory drive is combinational from state and owner.

## Test plan
- Port 0 write addr=0x10 data=0xDEADBEEF, then port 0 read 0x10.
  - Write ack in cycle N+2 with `mem_we`=1 in N+1 only.
  - Read ack with `p0_rdata`=0xDEADBEEF.
- Both req in the same cycle after reset: port 0 granted first, port 1 acked 2 cycles later.
- Both reqs held for 6 accesses: ack order 0,1,0,1,0,1, one ack every 2 cycles.
- Port 1 write addr=0x22:
  - `p1_ack`=1 and `p1_err`=1 in the same cycle; `mem_we` stays 0 throughout.
  - A subsequent read of 0x20 returns the prior contents.
- `rst` asserted in the ACCESS cycle of a port 0 read: no `p0_ack`, `busy`=0 and all outputs at reset values the next cycle.
- Port 0 read while port 1 idle: `p1_rdata` and `p1_ack` unchanged; `p0_rdata` holds its value across a later port 0 write.
